dualport_ram_p: RTL

DUALPORT_RAM_P -- requirements
Module: dualport_ram_p

---
 rtl/dualport_ram_p.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dualport_ram_p.sv
`default_nettype none
// ============================================================================
// Module      : dualport_ram_p
// Description : True dual-port RAM with a zero-fill sweep after reset,
//               port A priority on same-address writes, optional output reg.
// Revision    : 1.0 - initial release
// ============================================================================
module dualport_ram_p #(
    parameter int DW         = 8,
    parameter int AW         = 4,
    parameter int RD_MODE    = 0,
    parameter int OUT_REG    = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_a,
    input  logic          w_a,
    input  logic [AW-1:0] add_a,
    input  logic [DW-1:0] d_in_a,
    output logic [DW-1:0] d_out_a,
    output logic          vld_a,
    input  logic          en_b,
    input  logic          w_b,
    input  logic [AW-1:0] add_b,
    input  logic [DW-1:0] d_in_b,
    output logic [DW-1:0] d_out_b,
    output logic          vld_b,
    output logic          busy,
    output logic          collision
);

    localparam int            c_DEPTH     = 1 << AW;
    localparam logic [AW-1:0] c_LAST_ADDR = {AW{1'b1}};
    localparam logic [0:0]    c_ST_INIT   = 1'b0;
    localparam logic [0:0]    c_ST_READY  = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic [DW-1:0] r_mem [c_DEPTH];
    logic          r_collision;
    logic          r_s1_vld_a;
    logic          r_s1_vld_b;
    logic [DW-1:0] r_s1_dat_a;
    logic [DW-1:0] r_s1_dat_b;

    logic          w_ready;
    logic          w_clr;
    logic          w_same_wr;
    logic          w_wr_a;
    logic          w_wr_b;
    logic          w_ret_a;
    logic          w_ret_b;
    logic [DW-1:0] w_ret_dat_a;
    logic [DW-1:0] w_ret_dat_b;

    assign w_ready   = !rst && (r_state == c_ST_READY);
    assign w_clr     = !rst && (r_state == c_ST_INIT);
    assign w_same_wr = w_ready && en_a && w_a && en_b && w_b && (add_a == add_b);
    assign w_wr_a    = w_ready && en_a && w_a;
    assign w_wr_b    = w_ready && en_b && w_b && !w_same_wr;

    // A write cycle only produces output data in write-first mode
    assign w_ret_a     = w_ready && en_a && (!w_a || (RD_MODE != 0));
    assign w_ret_b     = w_ready && en_b && (!w_b || (RD_MODE != 0));
    assign w_ret_dat_a = w_a ? d_in_a : r_mem[add_a];
    // A dropped B write reports the value that actually landed (port A's)
    assign w_ret_dat_b = !w_b ? r_mem[add_b] : (w_same_wr ? d_in_a : d_in_b);

    assign busy      = (r_state == c_ST_INIT);
    assign collision = r_collision;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLR_ON_RST != 0) ? c_ST_INIT : c_ST_READY;
            r_clr_cnt <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == c_LAST_ADDR) begin
                r_state <= c_ST_READY;
            end
        end
    end

    // Memory has no reset so contents survive rst when the sweep is disabled
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            if (w_wr_a) begin
                r_mem[add_a] <= d_in_a;
            end
            if (w_wr_b) begin
                r_mem[add_b] <= d_in_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision <= 1'b0;
            r_s1_vld_a  <= 1'b0;
            r_s1_vld_b  <= 1'b0;
            r_s1_dat_a  <= '0;
            r_s1_dat_b  <= '0;
        end else begin
            r_collision <= w_same_wr;
            r_s1_vld_a  <= w_ret_a;
            r_s1_vld_b  <= w_ret_b;
            if (w_ret_a) begin
                r_s1_dat_a <= w_ret_dat_a;
            end
            if (w_ret_b) begin
                r_s1_dat_b <= w_ret_dat_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          r_s2_vld_a;
            logic          r_s2_vld_b;
            logic [DW-1:0] r_s2_dat_a;
            logic [DW-1:0] r_s2_dat_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_vld_a <= 1'b0;
                    r_s2_vld_b <= 1'b0;
                    r_s2_dat_a <= '0;
                    r_s2_dat_b <= '0;
                end else begin
                    r_s2_vld_a <= r_s1_vld_a;
                    r_s2_vld_b <= r_s1_vld_b;
                    if (r_s1_vld_a) begin
                        r_s2_dat_a <= r_s1_dat_a;
                    end
                    if (r_s1_vld_b) begin
                        r_s2_dat_b <= r_s1_dat_b;
                    end
                end
            end

            assign d_out_a = r_s2_dat_a;
            assign vld_a   = r_s2_vld_a;
            assign d_out_b = r_s2_dat_b;
            assign vld_b   = r_s2_vld_b;
        end else begin : g_no_out_reg
            assign d_out_a = r_s1_dat_a;
            assign vld_a   = r_s1_vld_a;
            assign d_out_b = r_s1_dat_b;
            assign vld_b   = r_s1_vld_b;
        end
    endgenerate

endmodule
`default_nettype wire
